// File: rtl/fsqrt_issue.sv
// -----------------------------------------------------------------------------
// fsqrt_issue -- issue/collect controller for the fixed-latency, non-stallable
// fsqrt pipeline.
//
// Requests are accepted with a valid/ready handshake and forwarded to the unit
// in the same cycle. Each request's tag travels down a LATENCY-deep shadow
// pipeline. The tag pops out of the last stage exactly when the unit's result
// is due. The tag is then paired with the result and written into an in-order
// response FIFO. The unit cannot stall, so requests are only accepted while
// (in flight + buffered) < DEPTH. That guarantees a FIFO slot for every
// result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake; req_data operand, req_tag dest tag
//   fu_input_a/valid    operand and issue strobe to the unit
//   fu_result/out_valid result and result strobe from the unit
//   rsp_valid/ready     response handshake; rsp_data result, rsp_tag tag
//   busy                something is in flight or buffered
//   lat_err             sticky: the result strobe disagreed with the shadow
//                       pipeline, or a push hit a full FIFO
//
// Build option:
//   FSQRT_ISSUE_BYPASS_EN -- if the FIFO is empty and the consumer is ready,
//   a result goes straight to rsp_* in its arrival cycle. It is not written
//   to the FIFO.
// -----------------------------------------------------------------------------
module fsqrt_issue #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_data,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fu_input_a,
    output logic             fu_input_valid,
    input  logic [31:0]      fu_result,
    input  logic             fu_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             lat_err
);

    localparam int DATA_W = 32;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + LATENCY + 1) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Shadow pipeline: valid bits are control (reset), tags are data (no reset).
    logic [LATENCY-1:0] sh_vld_q;
    logic [TAG_W-1:0]   sh_tag_q [LATENCY];

    // Response FIFO storage and bookkeeping.
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               lat_err_q, lat_err_d;

    logic               accept;
    logic               exp_vld;
    logic [TAG_W-1:0]   exp_tag;
    logic               res_ok;
    logic               byp_take;
    logic               push;
    logic               pop;
    logic               overflow;
    logic [CNT_W-1:0]   occ;
    entry_t             head;

    assign exp_vld = sh_vld_q[LATENCY-1];
    assign exp_tag = sh_tag_q[LATENCY-1];
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        occ        = inflight_q + count_q;
        // A pop in this cycle is deliberately ignored, which keeps rsp_ready
        // off the req_ready path.
        req_ready  = !rst && (occ < DEPTH_C);
        accept     = req_valid && req_ready;

        fu_input_valid = accept;
        fu_input_a     = req_data;

        res_ok   = fu_out_valid && exp_vld;
`ifdef FSQRT_ISSUE_BYPASS_EN
        byp_take = (count_q == '0) && res_ok && rsp_ready;
`else
        byp_take = 1'b0;
`endif
        overflow = res_ok && !byp_take && (count_q == DEPTH_C);
        push     = res_ok && !byp_take && !overflow;
        pop      = (count_q != '0) && rsp_ready;

        rsp_valid = (count_q != '0) || byp_take;
        rsp_data  = (count_q != '0) ? head.data : '0;
        rsp_tag   = (count_q != '0) ? head.tag  : '0;
        if (byp_take) begin
            rsp_data = fu_result;
            rsp_tag  = exp_tag;
        end

        // A bypassed result still retires its shadow entry, so the credit
        // count stays correct.
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(exp_vld);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        lat_err_d  = lat_err_q || (fu_out_valid != exp_vld) || overflow;

        busy    = (occ != '0);
        lat_err = lat_err_q;
    end

    // ---- stage boundary: shadow pipeline advance ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_vld_q <= '0;
        end else begin
            sh_vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                sh_vld_q[i] <= sh_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        sh_tag_q[0] <= req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            sh_tag_q[i] <= sh_tag_q[i-1];
        end
    end

    // ---- stage boundary: result capture into the response FIFO ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{tag: exp_tag, data: fu_result};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            lat_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            lat_err_q  <= lat_err_d;
        end
    end

endmodule

// File: tb/tb_fsqrt_issue.sv
module tb_fsqrt_issue;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
`ifdef FSQRT_ISSUE_BYPASS_EN
    localparam int RSP_LAT = LAT;
`else
    localparam int RSP_LAT = LAT + 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_data;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      fu_input_a;
    logic             fu_input_valid;
    logic [31:0]      fu_result;
    logic             fu_out_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic             lat_err;
    logic             spur;

    always #5 clk = ~clk;

    fsqrt_issue #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_tag(req_tag),
        .fu_input_a(fu_input_a), .fu_input_valid(fu_input_valid),
        .fu_result(fu_result), .fu_out_valid(fu_out_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .busy(busy), .lat_err(lat_err)
    );

    // Unit stub: operand+1 after LAT cycles; spur injects a stray strobe.
    logic [32:0] dl [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) dl[i] <= '0;
        end else begin
            dl[0] <= {fu_input_valid, fu_input_a + 32'd1};
            for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
        end
    end
    assign fu_out_valid = dl[LAT-1][32] | spur;
    assign fu_result    = spur ? 32'hDEAD_BEEF : dl[LAT-1][31:0];

    int checks = 0;
    int errors = 0;

    // Reference model: issue-order queue of {tag, expected result} plus the
    // number of accepted-but-not-yet-delivered requests.
    logic [TAG_W+31:0] exp_q [$];
    int                outstanding = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cycle(input bit drive);
        logic [TAG_W+31:0] e;
        bit acc;
        cyc();
        if (drive) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_data  = $urandom;
            req_tag   = TAG_W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end else begin
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        #2;
        chk("rnd_req_ready", 32'(req_ready), 32'(outstanding < DEPTH));
        chk("rnd_busy", 32'(busy), 32'(outstanding != 0));
        acc = req_valid && (outstanding < DEPTH);
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rnd_rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rnd_rsp_tag", 32'(rsp_tag), 32'(e[TAG_W+31:32]));
                chk("rnd_rsp_data", rsp_data, e[31:0]);
            end
            outstanding--;
        end
        if (acc) begin
            exp_q.push_back({req_tag, req_data + 32'd1});
            outstanding++;
        end
    endtask

    initial begin
        int acc_n;
        rst = 1'b1; req_valid = 1'b0; req_data = '0; req_tag = '0;
        rsp_ready = 1'b0; spur = 1'b0;

        // Reset state
        cyc(); #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fu_valid", 32'(fu_input_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lat_err", 32'(lat_err), 32'd0);
        cyc(); rst = 1'b0; #2;
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // Single request
        cyc(); req_valid = 1'b1; req_data = 32'h4080_0000; req_tag = 5'd7; rsp_ready = 1'b1; #2;
        chk("t1_fu_valid", 32'(fu_input_valid), 32'd1);
        chk("t1_fu_a", fu_input_a, 32'h4080_0000);
        for (int k = 1; k <= 5; k++) begin
            cyc(); req_valid = 1'b0; #2;
            chk("t1_rsp_valid", 32'(rsp_valid), 32'(k == RSP_LAT));
            if (k == RSP_LAT) begin
                chk("t1_rsp_data", rsp_data, 32'h4080_0001);
                chk("t1_rsp_tag", 32'(rsp_tag), 32'd7);
            end
        end
        chk("t1_busy", 32'(busy), 32'd0);

        // Fill and drain
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(); req_valid = 1'b1; req_tag = TAG_W'(i + 1);
            req_data = 32'h3F80_0000 + 32'(i << 4); rsp_ready = 1'b0; #2;
            chk("t2_req_ready", 32'(req_ready), 32'(i < 4));
            if (req_valid && req_ready) acc_n++;
        end
        chk("t2_accepts", 32'(acc_n), 32'd4);
        cyc(); req_valid = 1'b0; #2;
        chk("t2_req_ready_full", 32'(req_ready), 32'd0);
        for (int j = 1; j <= 4; j++) begin
            cyc(); rsp_ready = 1'b1; #2;
            chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t2_rsp_tag", 32'(rsp_tag), 32'(j));
            chk("t2_rsp_data", rsp_data, 32'h3F80_0001 + 32'((j - 1) << 4));
            chk("t2_req_ready_drain", 32'(req_ready), 32'(j != 1));
        end
        cyc(); #2;
        chk("t2_empty", 32'(rsp_valid), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);

        // Simultaneous push and pop with two entries buffered
        for (int i = 0; i < 3; i++) begin
            cyc(); req_valid = 1'b1; req_tag = TAG_W'(10 + i);
            req_data = 32'h0000_1000 + 32'(i); rsp_ready = 1'b0; #2;
        end
        for (int k = 3; k <= 8; k++) begin
            cyc(); req_valid = 1'b0; rsp_ready = (k >= 5); #2;
            if (k == 3) chk("t3_rsp_valid_3", 32'(rsp_valid), 32'd0);
            else if (k == 4) chk("t3_rsp_valid_4", 32'(rsp_valid), 32'd1);
            else if (k <= 7) begin
                chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("t3_rsp_tag", 32'(rsp_tag), 32'(10 + k - 5));
                chk("t3_rsp_data", rsp_data, 32'h0000_1001 + 32'(k - 5));
            end else begin
                chk("t3_rsp_valid_end", 32'(rsp_valid), 32'd0);
                chk("t3_busy", 32'(busy), 32'd0);
            end
        end

        // Spurious result
        cyc(); spur = 1'b1; #2;
        chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); spur = 1'b0; #2;
            chk("t4_lat_err", 32'(lat_err), 32'd1);
            chk("t4_no_rsp_after", 32'(rsp_valid), 32'd0);
        end
        cyc(); rst = 1'b1; #2;
        chk("t4_rst_req_ready", 32'(req_ready), 32'd0);
        cyc(); rst = 1'b0; #2;
        chk("t4_lat_err_clr", 32'(lat_err), 32'd0);
        chk("t4_req_ready", 32'(req_ready), 32'd1);

        // Reset mid-flight
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); req_valid = 1'b1; req_tag = TAG_W'(20 + i); req_data = 32'h55 + 32'(i); #2;
            chk("t5_accept", 32'(req_ready), 32'd1);
        end
        cyc(); req_valid = 1'b0; rst = 1'b1; #2;
        chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
        cyc(); rst = 1'b0; #2;
        chk("t5_rel_req_ready", 32'(req_ready), 32'd1);
        chk("t5_rel_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(); #2;
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
            chk("t5_lat_err", 32'(lat_err), 32'd0);
        end

        // Response held while the consumer stalls
        cyc(); req_valid = 1'b1; req_tag = 5'd25; req_data = 32'h4110_0000; rsp_ready = 1'b0; #2;
        for (int k = 1; k <= 7; k++) begin
            cyc(); req_valid = 1'b0; rsp_ready = (k >= 6); #2;
            chk("t6_rsp_valid", 32'(rsp_valid), 32'(k >= 4 && k <= 6));
            if (k >= 4 && k <= 6) begin
                chk("t6_rsp_tag", 32'(rsp_tag), 32'd25);
                chk("t6_rsp_data", rsp_data, 32'h4110_0001);
            end
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) rnd_cycle(1'b1);
        for (int n = 0; n < 60 && outstanding != 0; n++) rnd_cycle(1'b0);
        chk("drain_outstanding", 32'(outstanding), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        rnd_cycle(1'b0);
        chk("rnd_lat_err", 32'(lat_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fsqrt_issue.md
# fsqrt_issue

Request-side issue/collect controller for the fixed-latency, non-stallable `fsqrt` pipeline. It accepts tagged square-root requests from the core with a valid/ready handshake and drives the unit's `input_a`/`input_valid`. It tracks each request's destination tag through a LATENCY-deep shadow pipeline and captures `result`/`out_valid` into an in-order response FIFO with backpressure. A credit scheme guarantees that no result is ever dropped, because the unit itself cannot stall.

## Interface
Parameters:
- `LATENCY`, 3: cycles from `fu_input_valid` to the matching `fu_out_valid`. Must be ≥1.
- `DEPTH`, 4: response FIFO entries. This is also the maximum number of outstanding requests.
- `TAG_W`, 5: destination tag width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request can be accepted.
- `req_data`  in  32  IEEE-754 single operand.
- `req_tag`  in  TAG_W  destination tag.
- `fu_input_a`  out  32  operand to the unit.
- `fu_input_valid`  out  1  issue strobe to the unit.
- `fu_result`  in  32  unit result.
- `fu_out_valid`  in  1  unit result strobe.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  32  result.
- `rsp_tag`  out  TAG_W  tag of the result.
- `busy`  out  1  any request is in flight or buffered.
- `lat_err`  out  1  sticky latency-mismatch flag.

## Operation
- Accept occurs when `req_valid && req_ready`.
- On accept:
  - `fu_input_valid` = 1 and `fu_input_a` = `req_data`, both combinational in the same cycle.
  - `{1, req_tag}` enters stage 0 of the tag shadow pipeline.
- When there is no accept: `fu_input_valid` = 0, and `fu_input_a` = `req_data` (don't-care to the unit).
- The shadow pipeline shifts one stage per cycle. Its stage LATENCY-1 output is the expected tag for the current cycle's `fu_out_valid`.
- When `fu_out_valid` is high and the expected entry is valid: push `{expected tag, fu_result}` into the FIFO.
- `lat_err` sets on either mismatch, and the offending result is dropped:
  - `fu_out_valid` high with the expected entry invalid;
  - the expected entry valid with `fu_out_valid` low.
- `lat_err` clears only on `rst`.
- Credit accounting:
  - `inflight` counts valid shadow stages; `count` is FIFO occupancy.
  - `req_ready` = `!rst && (inflight + count < DEPTH)`.
  - A pop in the same cycle does not raise `req_ready`, so there is no combinational `rsp_ready`→`req_ready` path.
- FIFO:
  - Circular buffer with read and write pointers mod DEPTH.
  - `rsp_valid` = `count != 0`.
  - `rsp_data`/`rsp_tag` come from the head entry.
  - Pop occurs on `rsp_valid && rsp_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Push while full cannot occur by construction. If it does occur, `lat_err` sets and the push is discarded.
- Responses always leave in issue order.
- `busy` = `inflight + count != 0`.

## Timing
- Reset values: `req_ready` 0 while `rst` is high, 1 in the first cycle after release. `fu_input_valid` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_tag` 0, `busy` 0, `lat_err` 0.
- Reset clears the shadow pipeline, FIFO pointers and counters.
- Reset mid-operation discards all in-flight and buffered results. Any `fu_out_valid` for a pre-reset issue that arrives after release sets `lat_err`. The system resets `fsqrt` together with this block, so this case does not arise in normal use.
- Latency (default build): accept in cycle N → `fu_out_valid` in cycle N+LATENCY → `rsp_valid` in cycle N+LATENCY+1.
- Throughput: one accept per cycle while credits remain. Full rate is sustained when `rsp_ready` is held high and DEPTH ≥ LATENCY+1.

## Configuration
- `FSQRT_ISSUE_BYPASS_EN` defined:
  - Applies when the FIFO is empty, a result arrives, and `rsp_ready` is high.
  - The result goes to `rsp_*` combinationally in cycle N+LATENCY and is not written to the FIFO.
  - Latency is LATENCY.
  - Credit accounting is unchanged.
  - When `rsp_ready` is low, the result is pushed normally.
- Not defined: every result passes through the FIFO, and latency is LATENCY+1.

## Test plan
The bench drives `fu_*` from a stub that returns operand+1 after LATENCY=3 cycles.

- **Single request.** Reset, then one request with `req_data`=0x40800000 and `req_tag`=7, `rsp_ready`=1 → `fu_input_valid` high in cycle 0; `rsp_valid` in cycle 4 with `rsp_data`=0x40800001 and `rsp_tag`=7; `busy` 0 in cycle 5.
- **Fill and drain.** Hold `rsp_ready`=0 and offer 6 back-to-back requests with tags 1..6 → exactly 4 accepted; `req_ready` low from cycle 4. Then set `rsp_ready`=1 → responses tags 1,2,3,4 in order; `req_ready` returns one cycle after the first pop.
- **Simultaneous push and pop.** With `count`=2 and `rsp_ready`=1, a result arrives → `count` stays 2 and ordering is preserved.
- **Spurious result.** Pulse `fu_out_valid` with nothing issued → `lat_err`=1 and remains 1; no response is produced; `rst` clears it.
- **Reset mid-flight.** Assert `rst` in cycle 2 after 2 accepts (stub also reset) → no `rsp_valid` afterward, `busy`=0, `req_ready`=1 in the cycle after release.
- **Bypass (macro on).** Single request in cycle 0 with `rsp_ready`=1 → `rsp_valid` in cycle 3. With `rsp_ready`=0 until cycle 6 → response held from cycle 4.
